axi_lite_arb: RTL
=================

# axi_lite_arb

Two-master AXI-lite arbiter that shares the single memory bus port between the IFU (read-only master) and the LSU (read/write master). It sits between the core's fetch/load-store units and the SoC memory slave. It grants one whole transaction at a time and routes handshakes and response data back to the owning master. Fairness is round-robin between IFU and LSU.

## Interface
- `ADDR_W`, 32, address width (matches `ysyx_23060251_axi_addr_bus`).
- `DATA_W`, 32, data width (matches `ysyx_23060251_axi_data_bus`).
- `clk_i` in 1: single clock.
- `rst_i` in 1: synchronous, active-high reset.
- `ifu_ar_valid_i` / `ifu_ar_addr_i` / `ifu_ar_ready_o`, in/in/out, 1/ADDR_W/1: IFU read address.
- `ifu_r_valid_o` / `ifu_r_data_o` / `ifu_r_resp_o` / `ifu_r_ready_i`, out/out/out/in, 1/DATA_W/2/1: IFU read data.
- `lsu_ar_valid_i` / `lsu_ar_addr_i` / `lsu_ar_ready_o`, in/in/out, 1/ADDR_W/1: LSU read address.
- `lsu_r_valid_o` / `lsu_r_data_o` / `lsu_r_resp_o` / `lsu_r_ready_i`, out/out/out/in, 1/DATA_W/2/1: LSU read data.
- `lsu_aw_valid_i` / `lsu_aw_addr_i` / `lsu_aw_ready_o`, in/in/out, 1/ADDR_W/1: LSU write address.
- `lsu_w_valid_i` / `lsu_w_data_i` / `lsu_w_strb_i` / `lsu_w_ready_o`, in/in/in/out, 1/DATA_W/DATA_W/8/1: LSU write data.
- `lsu_b_valid_o` / `lsu_b_resp_o` / `lsu_b_ready_i`, out/out/in, 1/2/1: LSU write response.
- `slv_ar_*`, `slv_r_*`, `slv_aw_*`, `slv_w_*`, `slv_b_*`: the same five channels toward the memory slave, with directions mirrored.

## Operation
- States are one-hot: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP. A 1-bit `owner` register is 0 for IFU and 1 for LSU. A 1-bit `last` register records the last granted master.
- Requests are sampled only in IDLE:
  - `req_if = ifu_ar_valid_i`
  - `req_lr = lsu_ar_valid_i`
  - `req_lw = lsu_aw_valid_i | lsu_w_valid_i`
- If `req_lw` and `req_lr` are both set, write wins (the LSU should not issue both).
- IFU vs LSU tie: grant the master that is not `last`. A sole requester is always granted.
- On grant:
  - Read goes to RD_ADDR. LSU write goes to WR_REQ with `aw_done` and `w_done` cleared.
  - `owner` is latched and `last` is set to `owner`.
- RD_ADDR:
  - `slv_ar_valid_o`/`slv_ar_addr_o` carry the owner's AR combinationally; the owner's `ar_ready` equals `slv_ar_ready_i`.
  - On AR handshake, go to RD_DATA.
- RD_DATA:
  - `slv_r_ready_o` equals the owner's `r_ready`. The owner's `r_valid`/`data`/`resp` equal the slave's. The non-owner sees `r_valid = 0`.
  - On R handshake, go to IDLE.
- WR_REQ:
  - AW and W are forwarded independently; each is masked once its done-flag is set.
  - Go to WR_RESP when both handshakes have completed, in the same cycle or in different cycles.
- WR_RESP:
  - B is forwarded. On B handshake, go to IDLE.
- Outside its active state, every forwarded valid/ready is 0. IFU write channels do not exist.
- `resp` codes (SLVERR/DECERR) pass through unmodified. The arbiter never generates errors.
- Reset:
  - state=IDLE, `owner`=0, `last`=0 (IFU), so the first tie goes to LSU. Done-flags are cleared.
  - Reset mid-transaction drops the transaction. The slave shares `rst_i`.
- Reset values of all outputs: all valid/ready outputs are 0. Address/data/resp outputs are 0 (muxed against a zero default when no owner is active).

## Timing
- Grant latency is 1 cycle: a request seen in IDLE at cycle N is visible on `slv_ar_valid_o`/`slv_aw_valid_o` at N+1.
- There are no bubbles inside a transaction. All datapath is combinational pass-through, so slave-side latency is added with zero extra cycles.
- After every transaction there is exactly one IDLE cycle before the next grant. Best-case read occupancy is 3 cycles (IDLE, RD_ADDR, RD_DATA).
- Masters must hold valid and payload stable until their handshake (AXI rule). The arbiter does not register payloads.
- A request deasserted in IDLE before grant is not serviced. IFU `ar_valid` rising while the LSU owns the bus waits; no handshake is visible to the IFU.

## Structure
- Package `axi_arb_pkg`: state localparams (one-hot, 5 bits), owner encoding (`OWN_IFU=0`, `OWN_LSU=1`), resp codes (OKAY=2'b00, SLVERR=2'b10, DECERR=2'b11).
- Sub-module `rr_arb2`: a combinational 2-way round-robin picker with inputs `req[1:0]` and `last`, and outputs `gnt[1:0]`.
- The top level holds the FSM, the done-flags and the channel muxes.

## Test plan
- IFU-only read of 0x8000_0000; slave returns 0x0000_0413 after 2 wait cycles → IFU gets `r_valid` with that data; `lsu_r_valid_o` stays 0; the next grant comes after one IDLE cycle.
- IFU and LSU reads asserted in the same cycle straight after reset → LSU granted first, IFU second. Repeat the tie → grant order alternates strictly.
- LSU write of addr 0xa000_03f8, data 0x41, strb 4'b0001 with W accepted 2 cycles before AW → single B forwarded with OKAY; state goes WR_REQ→WR_RESP→IDLE.
- LSU write with AW and W accepted in the same cycle → WR_RESP entered next cycle; no duplicate AW or W handshake.
- Slave returns DECERR (2'b11) on an IFU read → `ifu_r_resp_o`=2'b11, unchanged; arbiter returns to IDLE.
- `rst_i` asserted during RD_DATA → next cycle all valid/ready outputs are 0 and state is IDLE; a subsequent tie is granted to LSU.

Source files
------------

// File: rtl/axi_lite_arb_pkg.sv
// Shared encodings for the two-master AXI-lite arbiter: one-hot FSM states,
// owner encoding and AXI response codes.
package axi_arb_pkg;
    typedef logic [4:0] state_t;

    localparam state_t ST_IDLE    = 5'b00001;
    localparam state_t ST_RD_ADDR = 5'b00010;
    localparam state_t ST_RD_DATA = 5'b00100;
    localparam state_t ST_WR_REQ  = 5'b01000;
    localparam state_t ST_WR_RESP = 5'b10000;

    localparam logic OWN_IFU = 1'b0;
    localparam logic OWN_LSU = 1'b1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: a sole requester wins, a tie goes to the
// requester that was not granted last (bit 0 = IFU, bit 1 = LSU).
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);
    assign gnt[0] = req[0] & (~req[1] | last);
    assign gnt[1] = req[1] & (~req[0] | ~last);
endmodule

// File: rtl/axi_lite_arb.sv
// Shares one AXI-lite slave port between the IFU (read-only) and the LSU,
// granting whole transactions round-robin with pure combinational routing.
module axi_lite_arb
    import axi_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                ifu_ar_valid_i,
    input  logic [ADDR_W-1:0]   ifu_ar_addr_i,
    output logic                ifu_ar_ready_o,
    output logic                ifu_r_valid_o,
    output logic [DATA_W-1:0]   ifu_r_data_o,
    output logic [1:0]          ifu_r_resp_o,
    input  logic                ifu_r_ready_i,
    input  logic                lsu_ar_valid_i,
    input  logic [ADDR_W-1:0]   lsu_ar_addr_i,
    output logic                lsu_ar_ready_o,
    output logic                lsu_r_valid_o,
    output logic [DATA_W-1:0]   lsu_r_data_o,
    output logic [1:0]          lsu_r_resp_o,
    input  logic                lsu_r_ready_i,
    input  logic                lsu_aw_valid_i,
    input  logic [ADDR_W-1:0]   lsu_aw_addr_i,
    output logic                lsu_aw_ready_o,
    input  logic                lsu_w_valid_i,
    input  logic [DATA_W-1:0]   lsu_w_data_i,
    input  logic [DATA_W/8-1:0] lsu_w_strb_i,
    output logic                lsu_w_ready_o,
    output logic                lsu_b_valid_o,
    output logic [1:0]          lsu_b_resp_o,
    input  logic                lsu_b_ready_i,
    output logic                slv_ar_valid_o,
    output logic [ADDR_W-1:0]   slv_ar_addr_o,
    input  logic                slv_ar_ready_i,
    input  logic                slv_r_valid_i,
    input  logic [DATA_W-1:0]   slv_r_data_i,
    input  logic [1:0]          slv_r_resp_i,
    output logic                slv_r_ready_o,
    output logic                slv_aw_valid_o,
    output logic [ADDR_W-1:0]   slv_aw_addr_o,
    input  logic                slv_aw_ready_i,
    output logic                slv_w_valid_o,
    output logic [DATA_W-1:0]   slv_w_data_o,
    output logic [DATA_W/8-1:0] slv_w_strb_o,
    input  logic                slv_w_ready_i,
    input  logic                slv_b_valid_i,
    input  logic [1:0]          slv_b_resp_i,
    output logic                slv_b_ready_o
);
    state_t     state_q, state_d;
    logic       owner_q, last_q, aw_done_q, w_done_q;
    logic [1:0] gnt;
    logic       req_lr, req_lw;
    logic       in_rd_addr, in_rd_data, in_wr_req, in_wr_resp;
    logic       aw_hs, w_hs;

    assign req_lr = lsu_ar_valid_i;
    assign req_lw = lsu_aw_valid_i | lsu_w_valid_i;

    rr_arb2 u_rr (
        .req  ({req_lr | req_lw, ifu_ar_valid_i}),
        .last (last_q),
        .gnt  (gnt)
    );

    assign in_rd_addr = (state_q == ST_RD_ADDR);
    assign in_rd_data = (state_q == ST_RD_DATA);
    assign in_wr_req  = (state_q == ST_WR_REQ);
    assign in_wr_resp = (state_q == ST_WR_RESP);

    assign aw_hs = slv_aw_valid_o & slv_aw_ready_i;
    assign w_hs  = slv_w_valid_o & slv_w_ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            owner_q   <= OWN_IFU;
            last_q    <= OWN_IFU;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && gnt != 2'b00) begin
                owner_q   <= gnt[1];
                last_q    <= gnt[1];
                aw_done_q <= 1'b0;
                w_done_q  <= 1'b0;
            end else if (in_wr_req) begin
                aw_done_q <= aw_done_q | aw_hs;
                w_done_q  <= w_done_q | w_hs;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                // A write outranks an LSU read when both are (wrongly) raised.
                if (gnt[1] && req_lw)  state_d = ST_WR_REQ;
                else if (gnt != 2'b00) state_d = ST_RD_ADDR;
            end
            ST_RD_ADDR: if (slv_ar_valid_o && slv_ar_ready_i) state_d = ST_RD_DATA;
            ST_RD_DATA: if (slv_r_valid_i && slv_r_ready_o)   state_d = ST_IDLE;
            ST_WR_REQ:  if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) state_d = ST_WR_RESP;
            ST_WR_RESP: if (slv_b_valid_i && slv_b_ready_o)   state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        slv_ar_valid_o = in_rd_addr & (owner_q ? lsu_ar_valid_i : ifu_ar_valid_i);
        slv_ar_addr_o  = in_rd_addr ? (owner_q ? lsu_ar_addr_i : ifu_ar_addr_i) : '0;
        ifu_ar_ready_o = in_rd_addr & ~owner_q & slv_ar_ready_i;
        lsu_ar_ready_o = in_rd_addr &  owner_q & slv_ar_ready_i;

        slv_r_ready_o  = in_rd_data & (owner_q ? lsu_r_ready_i : ifu_r_ready_i);
        ifu_r_valid_o  = in_rd_data & ~owner_q & slv_r_valid_i;
        lsu_r_valid_o  = in_rd_data &  owner_q & slv_r_valid_i;
        ifu_r_data_o   = (in_rd_data & ~owner_q) ? slv_r_data_i : '0;
        lsu_r_data_o   = (in_rd_data &  owner_q) ? slv_r_data_i : '0;
        ifu_r_resp_o   = (in_rd_data & ~owner_q) ? slv_r_resp_i : 2'b00;
        lsu_r_resp_o   = (in_rd_data &  owner_q) ? slv_r_resp_i : 2'b00;

        // Once a channel has handshaken, it stays masked so it is never issued twice.
        slv_aw_valid_o = in_wr_req & ~aw_done_q & lsu_aw_valid_i;
        slv_aw_addr_o  = in_wr_req ? lsu_aw_addr_i : '0;
        lsu_aw_ready_o = in_wr_req & ~aw_done_q & slv_aw_ready_i;
        slv_w_valid_o  = in_wr_req & ~w_done_q & lsu_w_valid_i;
        slv_w_data_o   = in_wr_req ? lsu_w_data_i : '0;
        slv_w_strb_o   = in_wr_req ? lsu_w_strb_i : '0;
        lsu_w_ready_o  = in_wr_req & ~w_done_q & slv_w_ready_i;

        slv_b_ready_o  = in_wr_resp & lsu_b_ready_i;
        lsu_b_valid_o  = in_wr_resp & slv_b_valid_i;
        lsu_b_resp_o   = in_wr_resp ? slv_b_resp_i : 2'b00;
    end
endmodule
